dispense_sequencer: RTL and testbench

- Downstream of the vending FSM. Consumes its registered out / change_1 / change_2 outputs; each cycle with any bit set is one vend/change event.
- Queues events in a small FIFO and drives the physical actuators in a fixed, non-overlapping order: product motor, then the 1-coin ejector, then the 2-coin ejector.
- Decouples single-cycle FSM decisions from multi-cycle mechanical timing.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/vend_req_fifo.sv | 83 ++++++++
 rtl/dispense_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_dispense_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the dispense sequencer and its request FIFO:
//   - state encodings for the actuation FSM (IDLE/LOAD/VEND/GAP/EJ1/EJ2)
//   - bit positions inside a queued request entry
//   - entry width
//   - small helper for sizing the phase counter
// ----------------------------------------------------------------------------
package vend_pkg;

  localparam int ENTRY_W = 3;
  localparam int BIT_OUT = 0;
  localparam int BIT_C1  = 1;
  localparam int BIT_C2  = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_VEND = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_EJ1  = 3'd4;
  localparam logic [2:0] S_EJ2  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    VEND = S_VEND,
    GAP  = S_GAP,
    EJ1  = S_EJ1,
    EJ2  = S_EJ2
  } state_t;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// ----------------------------------------------------------------------------
// vend_req_fifo
// Synchronous show-ahead FIFO for 3-bit dispense requests.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset (empties the FIFO)
//   push    in   write wdata this edge (accepted if not full, or if popping)
//   pop     in   discard head entry this edge (ignored when empty)
//   wdata   in   entry to write
//   rdata   out  head entry (valid when !empty)
//   full    out  count == DEPTH
//   empty   out  count == 0
//   count   out  number of stored entries
//   dropped out  push this edge is being rejected because the FIFO is full
// ----------------------------------------------------------------------------
module vend_req_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wdata,
  output logic [ENTRY_W-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               pop_s;
  logic               push_ok_s;

  // Handshake qualification; a pop frees a slot for a same-edge push.
  always_comb begin
    pop_s     = pop & ~empty;
    push_ok_s = push & (~full | pop_s);
    dropped   = push & full & ~pop_s;
  end

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// ----------------------------------------------------------------------------
// dispense_sequencer
// Queues vend/change events from the vending FSM and drives the actuators
// one at a time: product motor, then 1-coin ejector, then 2-coin ejector,
// with an all-off gap after every active phase.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   out          in   vend-product request
//   change_1     in   return 1-unit coin request
//   change_2     in   return 2-unit coin request
//   motor_on     out  product motor drive (registered)
//   coin1_eject  out  1-unit ejector drive (registered)
//   coin2_eject  out  2-unit ejector drive (registered)
//   busy         out  FSM not idle or requests pending
//   overflow     out  sticky: a request was dropped on a full FIFO
//   vend_count   out  [15:0] saturating count of VEND entries
//                     (only when DISPENSE_COUNT_EN is defined)
// Optional feature macro: DISPENSE_COUNT_EN
// ----------------------------------------------------------------------------
module dispense_sequencer
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES = 8,
  parameter int EJECT_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        out,
  input  logic        change_1,
  input  logic        change_2,
  output logic        motor_on,
  output logic        coin1_eject,
  output logic        coin2_eject,
  output logic        busy,
`ifdef DISPENSE_COUNT_EN
  output logic        overflow,
  output logic [15:0] vend_count
`else
  output logic        overflow
`endif
);

  localparam int MAXP  = max3(MOTOR_CYCLES, EJECT_CYCLES, GAP_CYCLES);
  localparam int CNT_W = ($clog2(MAXP) < 1) ? 1 : $clog2(MAXP);
  // Counter loads length-1 and leaves the phase on the cycle it reads 0.
  localparam logic [CNT_W-1:0] MOTOR_LOAD = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] EJECT_LOAD = CNT_W'(EJECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W-1:0]          cnt_nxt_s;
  logic [ENTRY_W-1:0]        rem_r;      // phases of current entry not yet run
  logic [ENTRY_W-1:0]        rem_nxt_s;
  logic                      pop_s;

  state_t                    disp_state_s;
  logic [CNT_W-1:0]          disp_cnt_s;
  logic [ENTRY_W-1:0]        disp_rem_s;
  logic                      disp_pop_s;

  logic [ENTRY_W-1:0]        req_s;
  logic                      push_s;
  logic [ENTRY_W-1:0]        fifo_data_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic                      dropped_s;

  assign req_s  = {change_2, change_1, out};
  assign push_s = (req_s != 3'b000);

  vend_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wdata   (req_s),
    .rdata   (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s),
    .dropped (dropped_s)
  );

  // Dispatch decision shared by LOAD and GAP exit: next pending phase in
  // fixed order, else fetch the next queued entry, else go idle.
  always_comb begin
    disp_state_s = IDLE;
    disp_cnt_s   = cnt_r;
    disp_rem_s   = rem_r;
    disp_pop_s   = 1'b0;
    if (rem_r[BIT_OUT]) begin
      disp_state_s        = VEND;
      disp_cnt_s          = MOTOR_LOAD;
      disp_rem_s[BIT_OUT] = 1'b0;
    end else if (rem_r[BIT_C1]) begin
      disp_state_s       = EJ1;
      disp_cnt_s         = EJECT_LOAD;
      disp_rem_s[BIT_C1] = 1'b0;
    end else if (rem_r[BIT_C2]) begin
      disp_state_s       = EJ2;
      disp_cnt_s         = EJECT_LOAD;
      disp_rem_s[BIT_C2] = 1'b0;
    end else if (!fifo_empty_s) begin
      disp_state_s = LOAD;
      disp_rem_s   = fifo_data_s;
      disp_pop_s   = 1'b1;
    end else begin
      disp_state_s = IDLE;
    end
  end

  // Next-state, phase counter and FIFO pop.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rem_nxt_s   = rem_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          rem_nxt_s   = fifo_data_s;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = disp_state_s;
        cnt_nxt_s   = disp_cnt_s;
        rem_nxt_s   = disp_rem_s;
        pop_s       = disp_pop_s;
      end
      VEND, EJ1, EJ2: begin
        if (cnt_r == '0) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = GAP_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_r == '0) begin
          state_nxt_s = disp_state_s;
          cnt_nxt_s   = disp_cnt_s;
          rem_nxt_s   = disp_rem_s;
          pop_s       = disp_pop_s;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
        rem_nxt_s   = '0;
      end
    endcase
  end

  // State, counter and current-entry registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rem_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

  // Moore actuator drives registered from next state; one-hot by construction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      motor_on    <= 1'b0;
      coin1_eject <= 1'b0;
      coin2_eject <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      motor_on    <= (state_nxt_s == VEND);
      coin1_eject <= (state_nxt_s == EJ1);
      coin2_eject <= (state_nxt_s == EJ2);
      overflow    <= overflow | dropped_s;
    end
  end

  assign busy = (state_r != IDLE) | (fifo_count_s != '0);

`ifdef DISPENSE_COUNT_EN
  // Saturating count of VEND phase entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vend_count <= 16'h0000;
    end else if ((state_nxt_s == VEND) && (state_r != VEND) &&
                 (vend_count != 16'hFFFF)) begin
      vend_count <= vend_count + 16'h0001;
    end else begin
      vend_count <= vend_count;
    end
  end
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dispense_sequencer
// Directed stimulus with a pulse scoreboard: each request pushes the actuator
// pulses it should produce (kind, first edge, length); a monitor measures the
// actual pulses and pops/compares on every falling edge of an actuator.
// Edge indices count DUT clock rising edges; outputs are sampled on the
// falling edge that follows.
// ----------------------------------------------------------------------------
module tb_dispense_sequencer;

  logic        clock;
  logic        reset;
  logic        out;
  logic        change_1;
  logic        change_2;
  logic        motor_on;
  logic        coin1_eject;
  logic        coin2_eject;
  logic        busy;
  logic        overflow;
`ifdef DISPENSE_COUNT_EN
  logic [15:0] vend_count;
`endif

  dispense_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .out         (out),
    .change_1    (change_1),
    .change_2    (change_2),
    .motor_on    (motor_on),
    .coin1_eject (coin1_eject),
    .coin2_eject (coin2_eject),
    .busy        (busy),
`ifdef DISPENSE_COUNT_EN
    .overflow    (overflow),
    .vend_count  (vend_count)
`else
    .overflow    (overflow)
`endif
  );

  typedef struct {
    int kind;   // 0 motor, 1 coin1, 2 coin2
    int start;  // first edge index with the actuator high
    int len;    // number of edges high
  } pulse_t;

  pulse_t sb[$];
  int     edge_idx = -1;
  int     checks   = 0;
  int     passes   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) edge_idx <= edge_idx + 1;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_idx);
  endfunction

  function automatic void expect_pulse(input int kind, input int start, input int len);
    pulse_t p;
    p.kind  = kind;
    p.start = start;
    p.len   = len;
    sb.push_back(p);
  endfunction

  task automatic run_until(input int target);
    while (edge_idx < target) @(negedge clock);
  endtask

  // Apply one request so it is sampled at the next edge k.
  task automatic req(input logic [2:0] bits, output int k);
    k = edge_idx + 1;
    {change_2, change_1, out} = bits;
    @(negedge clock);
    {change_2, change_1, out} = 3'b000;
  endtask

  task automatic monitor();
    logic [2:0] prev;
    logic [2:0] cur;
    int         st [3];
    pulse_t     p;
    prev = 3'b000;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev = 3'b000;
      end else begin
        cur = {coin2_eject, coin1_eject, motor_on};
        chk("one_hot", ($countones(cur) > 1) ? 1 : 0, 0);
        for (int i = 0; i < 3; i++) begin
          if (cur[i] && !prev[i]) st[i] = edge_idx;
          if (!cur[i] && prev[i]) begin
            if (sb.size() == 0) begin
              chk("unexpected_pulse_kind", i, -1);
            end else begin
              p = sb.pop_front();
              chk("pulse_kind", i, p.kind);
              chk("pulse_start", st[i], p.start);
              chk("pulse_len", edge_idx - st[i], p.len);
            end
          end
        end
        prev = cur;
      end
    end
  endtask

  initial begin
    int k;
    reset    = 1'b0;
    out      = 1'b0;
    change_1 = 1'b0;
    change_2 = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    #1;
    chk("rst_motor", int'(motor_on), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clock);
    @(negedge clock);
    chk("rst_c1_held", int'(coin1_eject), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Single vend: motor k+2..k+9, gap k+10..k+11, idle from k+12
    req(3'b001, k);
    expect_pulse(0, k + 2, 8);
    run_until(k + 1);
    chk("vend_busy_early", int'(busy), 1);
    run_until(k + 11);
    chk("vend_busy_gap", int'(busy), 1);
    chk("vend_motor_gap", int'(motor_on), 0);
    run_until(k + 12);
    chk("vend_busy_done", int'(busy), 0);
    repeat (3) @(negedge clock);

    // All three phases in order
    req(3'b111, k);
    expect_pulse(0, k + 2, 8);
    expect_pulse(1, k + 12, 4);
    expect_pulse(2, k + 18, 4);
    run_until(k + 23);
    chk("all_busy_gap", int'(busy), 1);
    run_until(k + 24);
    chk("all_busy_done", int'(busy), 0);
    repeat (2) @(negedge clock);

    // change_1 only
    req(3'b010, k);
    expect_pulse(1, k + 2, 4);
    run_until(k + 8);
    chk("c1_busy_done", int'(busy), 0);
    repeat (2) @(negedge clock);

    // out + change_1, then change_1 + change_2
    req(3'b011, k);
    expect_pulse(0, k + 2, 8);
    expect_pulse(1, k + 12, 4);
    run_until(k + 18);
    chk("oc1_busy_done", int'(busy), 0);
    req(3'b110, k);
    expect_pulse(1, k + 2, 4);
    expect_pulse(2, k + 8, 4);
    run_until(k + 14);
    chk("c12_busy_done", int'(busy), 0);
    repeat (2) @(negedge clock);

    // out held six edges: five accepted, sixth dropped on a full FIFO.
    // Back-to-back vends: VEND 8 + GAP 2 + LOAD 1 = 11-edge pitch.
    k = edge_idx + 1;
    out = 1'b1;
    for (int i = 0; i < 5; i++) expect_pulse(0, k + 2 + 11 * i, 8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 4) chk("ovf_not_yet", int'(overflow), 0);
      if (i == 5) chk("ovf_set", int'(overflow), 1);
    end
    out = 1'b0;
    run_until(k + 55);
    chk("burst_busy_gap", int'(busy), 1);
    run_until(k + 56);
    chk("burst_busy_done", int'(busy), 0);
    chk("ovf_sticky", int'(overflow), 1);
    repeat (2) @(negedge clock);

    // Asynchronous reset during the 4th motor cycle
    req(3'b001, k);
    run_until(k + 5);
    chk("mid_motor_on", int'(motor_on), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_motor", int'(motor_on), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_overflow", int'(overflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk("post_rst_busy", int'(busy), 0);

    // Three vends then a change_2-only request, on consecutive edges
    k = edge_idx + 1;
    out = 1'b1;
    repeat (3) @(negedge clock);
    out = 1'b0;
    change_2 = 1'b1;
    @(negedge clock);
    change_2 = 1'b0;
    expect_pulse(0, k + 2, 8);
    expect_pulse(0, k + 13, 8);
    expect_pulse(0, k + 24, 8);
    expect_pulse(2, k + 35, 4);
    run_until(k + 41);
    chk("cnt_busy_done", int'(busy), 0);
`ifdef DISPENSE_COUNT_EN
    chk("vend_count", int'(vend_count), 3);
`endif

    repeat (3) @(negedge clock);
    chk("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
